// File: rtl/io_uart_peripheral_if.sv
// Processor memory-side bus as seen by the IO-page responder.
interface io_uart_peripheral_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   logic [31:0] io_rdata;

   modport master (output mem_addr, output mem_wdata, output mem_wmask,
                   output mem_rstrb, input io_rdata);
   modport slave  (input mem_addr, input mem_wdata, input mem_wmask,
                   input mem_rstrb, output io_rdata);
endinterface

// File: rtl/io_uart_peripheral.sv
// IO-page responder: LED register plus 8N1 UART transmitter with status.
module io_uart_peripheral #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                    clk,
   input  logic                    reset,
   io_uart_peripheral_if.slave     bus,
   output logic [4:0]              LEDS,
   output logic                    TXD
);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   tx_state_t     state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    tx_byte;
   logic          overrun;
   logic          busy;

   logic io_sel, sel_leds, sel_dat, sel_cntl;
   logic wr_en, rd_en, baud_done;
   logic [31:0] rd_val;

   // Only the low byte and the decode bits of the bus are meaningful here.
   logic unused_bus;
   assign unused_bus = ^{bus.mem_addr[31:23], bus.mem_addr[21:5], bus.mem_addr[1:0],
                         bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

   assign io_sel    = bus.mem_addr[22];
   assign sel_leds  = bus.mem_addr[2];
   assign sel_dat   = bus.mem_addr[3];
   assign sel_cntl  = bus.mem_addr[4];
   assign wr_en     = io_sel & bus.mem_wmask[0];
   assign rd_en     = io_sel & bus.mem_rstrb;
   assign busy      = (state != IDLE);
   assign baud_done = (baud_cnt == BAUD_LAST);

   // Read mux: OR of every selected register, sampled before any same-cycle write.
   always_comb begin
      rd_val = 32'b0;
      if (sel_leds) rd_val = rd_val | {27'b0, LEDS};
      if (sel_cntl) rd_val = rd_val | {22'b0, busy, overrun, 8'b0};
   end

   // Register file: LEDS, registered read data and sticky overrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         LEDS     <= 5'b0;
         bus.io_rdata <= 32'b0;
         overrun  <= 1'b0;
      end else begin
         if (wr_en && sel_leds) LEDS <= bus.mem_wdata[4:0];
         if (rd_en) bus.io_rdata <= rd_val;
         // A dropped byte sets overrun even if a status read clears it this cycle.
         if (wr_en && sel_dat && busy) overrun <= 1'b1;
         else if (rd_en && sel_cntl) overrun <= 1'b0;
      end
   end

   // Transmit FSM with registered TXD; each state lasts one full baud period.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         tx_byte  <= 8'd0;
         TXD      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               TXD      <= 1'b1;
               baud_cnt <= '0;
               if (wr_en && sel_dat) begin
                  tx_byte <= bus.mem_wdata[7:0];
                  state   <= START;
                  TXD     <= 1'b0;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= 3'd0;
                  state    <= DATA;
                  TXD      <= tx_byte[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     TXD   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     TXD     <= tx_byte[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               TXD   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_io_uart_peripheral.sv
// Directed bench for the IO-page LED/UART responder with CLKS_PER_BIT=4.
module tb_io_uart_peripheral;
   localparam int CPB = 4;
   localparam logic [31:0] A_LEDS = 32'h0040_0004;
   localparam logic [31:0] A_DAT  = 32'h0040_0008;
   localparam logic [31:0] A_CNTL = 32'h0040_0010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] leds;
   logic       txd;
   int         vectors = 0;
   int         miscompares = 0;

   io_uart_peripheral_if bus ();

   io_uart_peripheral #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .LEDS  (leds),
      .TXD   (txd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_wmask = 4'h0;
      bus.mem_rstrb = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
      bus.mem_addr  = addr;
      bus.mem_wdata = data;
      bus.mem_wmask = mask;
      tick();
      idle_bus();
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
      bus.mem_addr  = addr;
      bus.mem_rstrb = 1'b1;
      tick();
      idle_bus();
      data = bus.io_rdata;
   endtask

   // Expected line level for frame slot k: start, 8 data bits LSB first, stop.
   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   task automatic test_reset();
      logic [31:0] rd;
      idle_bus();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      vectors++;
      if (leds !== 5'h0) begin miscompares++; $display("FAIL reset_leds got %h want 00", leds); end
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd got %b want 1", txd); end
      vectors++;
      if (bus.io_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", bus.io_rdata); end
      do_read(A_CNTL, rd);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_cntl got %h want 0", rd); end
   endtask

   task automatic test_leds();
      logic [31:0] rd;
      do_write(A_LEDS, 32'h15, 4'hF);
      vectors++;
      if (leds !== 5'h15) begin miscompares++; $display("FAIL leds_write got %h want 15", leds); end
      do_read(A_LEDS, rd);
      vectors++;
      if (rd !== 32'h15) begin miscompares++; $display("FAIL leds_read got %h want 15", rd); end
      // Read and write together: read returns pre-write value.
      bus.mem_addr  = A_LEDS;
      bus.mem_wdata = 32'hFFFF_FF03;
      bus.mem_wmask = 4'h1;
      bus.mem_rstrb = 1'b1;
      tick();
      idle_bus();
      vectors++;
      if (bus.io_rdata !== 32'h15) begin miscompares++; $display("FAIL leds_rw_same got %h want 15", bus.io_rdata); end
      vectors++;
      if (leds !== 5'h03) begin miscompares++; $display("FAIL leds_rw_new got %h want 03", leds); end
      // No read this cycle: io_rdata must hold.
      tick();
      vectors++;
      if (bus.io_rdata !== 32'h15) begin miscompares++; $display("FAIL rdata_hold got %h want 15", bus.io_rdata); end
   endtask

   task automatic test_frame();
      logic [7:0] b = 8'h41;
      logic [31:0] rd;
      do_write(A_DAT, {24'h0, b}, 4'hF);
      for (int i = 0; i < 10 * CPB; i++) begin
         vectors++;
         if (txd !== exp_bit(b, i / CPB)) begin
            miscompares++;
            $display("FAIL frame_txd cycle %0d got %b want %b", i, txd, exp_bit(b, i / CPB));
         end
         if (i == 20) begin
            bus.mem_addr  = A_CNTL;
            bus.mem_rstrb = 1'b1;
         end
         tick();
         idle_bus();
         if (i == 20) begin
            vectors++;
            if (bus.io_rdata !== 32'h200) begin miscompares++; $display("FAIL frame_busy got %h want 200", bus.io_rdata); end
         end
      end
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("FAIL frame_idle_txd got %b want 1", txd); end
      do_read(A_CNTL, rd);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL frame_done_cntl got %h want 0", rd); end
   endtask

   task automatic test_overrun();
      logic [7:0] b = 8'h41;
      logic [31:0] rd;
      do_write(A_DAT, {24'h0, b}, 4'hF);
      for (int i = 0; i < 10 * CPB; i++) begin
         vectors++;
         if (txd !== exp_bit(b, i / CPB)) begin
            miscompares++;
            $display("FAIL ovr_txd cycle %0d got %b want %b", i, txd, exp_bit(b, i / CPB));
         end
         if (i == 10) begin
            bus.mem_addr  = A_DAT;
            bus.mem_wdata = 32'h42;
            bus.mem_wmask = 4'h1;
         end
         if (i == 15 || i == 16) begin
            bus.mem_addr  = A_CNTL;
            bus.mem_rstrb = 1'b1;
         end
         tick();
         idle_bus();
         if (i == 15) begin
            vectors++;
            if (bus.io_rdata !== 32'h300) begin miscompares++; $display("FAIL ovr_first got %h want 300", bus.io_rdata); end
         end
         if (i == 16) begin
            vectors++;
            if (bus.io_rdata !== 32'h200) begin miscompares++; $display("FAIL ovr_second got %h want 200", bus.io_rdata); end
         end
      end
      do_read(A_CNTL, rd);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL ovr_after got %h want 0", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      do_write(A_DAT, 32'h00, 4'h1);
      repeat (10 * CPB) tick();
      // First IDLE cycle after STOP: a new byte must start immediately.
      do_write(A_DAT, 32'hFF, 4'h1);
      vectors++;
      if (txd !== 1'b0) begin miscompares++; $display("FAIL b2b_start got %b want 0", txd); end
      do_read(A_CNTL, rd);
      vectors++;
      if (rd !== 32'h200) begin miscompares++; $display("FAIL b2b_busy got %h want 200", rd); end
      repeat (10 * CPB) tick();
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int lows = 0;
      do_write(A_DAT, 32'h55, 4'h1);
      repeat (17) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("FAIL midrst_txd got %b want 1", txd); end
      do_read(A_CNTL, rd);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL midrst_busy got %h want 0", rd); end
      for (int i = 0; i < 12 * CPB; i++) begin
         if (txd !== 1'b1) lows++;
         tick();
      end
      vectors++;
      if (lows != 0) begin miscompares++; $display("FAIL midrst_quiet got %0d low cycles want 0", lows); end
   endtask

   task automatic test_io_sel();
      logic [31:0] rd;
      int lows = 0;
      do_write(A_LEDS, 32'h0A, 4'h1);
      do_write(32'h0000_0004, 32'h1F, 4'hF);
      vectors++;
      if (leds !== 5'h0A) begin miscompares++; $display("FAIL iosel_leds got %h want 0a", leds); end
      do_write(A_LEDS, 32'h1F, 4'h0);
      vectors++;
      if (leds !== 5'h0A) begin miscompares++; $display("FAIL wmask0_leds got %h want 0a", leds); end
      do_write(32'h0000_0008, 32'h00, 4'hF);
      do_write(A_DAT, 32'h00, 4'hE);
      for (int i = 0; i < 2 * CPB; i++) begin
         if (txd !== 1'b1) lows++;
         tick();
      end
      vectors++;
      if (lows != 0) begin miscompares++; $display("FAIL iosel_uart got %0d low cycles want 0", lows); end
      do_read(A_CNTL, rd);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL iosel_cntl got %h want 0", rd); end
   endtask

   initial begin
      test_reset();
      test_leds();
      test_frame();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_io_sel();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/io_uart_peripheral.md
Name: io_uart_peripheral

Overview:
- Memory-mapped IO responder that sits opposite the processor's memory interface and decodes IO-page accesses.
- Provides a LED output register and an 8N1 UART transmitter with status, turning the SOC's TXD pin from constant 0 into a real serial output.
- It is the responder to the CPU's loads and stores in the IO page. Plain RAM continues to serve non-IO addresses.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); legal range ≥2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- mem_addr  input  32  byte address from the processor.
- mem_wdata  input  32  store data.
- mem_wmask  input  4  byte write enables; nonzero means a write this cycle.
- mem_rstrb  input  1  read strobe, one cycle.
- io_rdata  output  32  read data, registered.
- LEDS  output  5  LED register.
- TXD  output  1  UART serial output; idle high.

Behaviour:
- io_sel = mem_addr[22]. Accesses with io_sel=0 are ignored entirely; no state changes.
- Register select is one-hot on word-address bits:
  - mem_addr[2] = LEDS
  - mem_addr[3] = UART_DAT
  - mem_addr[4] = UART_CNTL
- Write condition: io_sel & mem_wmask[0]. Only byte lane 0 matters; other wmask bits are don't-care.
- LEDS write: LEDS <= mem_wdata[4:0]; visible the cycle after the write.
- UART_DAT write while idle:
  - Latch mem_wdata[7:0].
  - FSM goes to START on the next edge. busy=1 and TXD=0 from that cycle.
- UART_DAT write while busy: byte dropped, sticky overrun <= 1, frame in progress unaffected.
- Reads (io_sel & mem_rstrb): io_rdata updates on the next edge, giving one-cycle latency. Value is the OR of all selected registers:
  - LEDS → {27'b0, LEDS}
  - UART_DAT → 0
  - UART_CNTL → {22'b0, busy at bit 9, overrun at bit 8, 8'b0}
- io_rdata holds its value when there is no IO read.
- A UART_CNTL read clears overrun. If an overrun-setting write occurs in the same cycle, set wins.
- A read and a write in the same cycle return pre-write state.
- TX FSM states:
  - IDLE: TXD=1.
  - START: TXD=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; 3-bit bit index.
  - STOP: TXD=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts on every state/bit advance.
- Frame length is exactly 10*CLKS_PER_BIT cycles of busy=1. A write in the first IDLE cycle after STOP is accepted, so back-to-back frames have no gap.
- TXD is registered with no glitches. busy = (state != IDLE).
- Reset values: LEDS=0, io_rdata=0, TXD=1, state=IDLE, busy=0, overrun=0, counters=0.
- Reset mid-frame aborts the frame: TXD=1 and busy=0 the cycle after reset is sampled. The latched byte is discarded.

Test Plan (CLKS_PER_BIT=4):
1. Assert reset 3 cycles → LEDS=0, TXD=1, io_rdata=0; reading 0x400010 returns 0x000.
2. Write 0x15 to 0x400004 with wmask=0xF → LEDS=0x15 next cycle. Then read 0x400004 → io_rdata=0x00000015 one cycle after rstrb.
3. Write 0x41 to 0x400008 → over 40 cycles TXD is 0(start), then 1,0,0,0,0,0,1,0, then 1(stop), each held 4 cycles. busy reads 0x200 during the frame and 0x000 afterward.
4. Write 0x41, then 0x42 at cycle 10 → only 0x41 is serialized. Reading CNTL returns 0x300, the next read returns 0x200. After the frame, a CNTL read returns 0x000.
5. Start a frame and assert reset at cycle 17 → TXD=1 and busy=0 next cycle; no further low bits appear.
6. Write 0x1F to 0x000004 (io_sel=0) and write with wmask=0 to 0x400004 → LEDS unchanged, no UART activity.
